// File: rtl/mem_controller.sv
// Memory-side responder: word-addressed internal RAM with a fixed multi-cycle
// access latency and a Valid/ready handshake toward the control unit.
//
// state | meaning
// IDLE  | ready high, waiting for Valid to accept a request
// BUSY  | ready low, latency counter running; access happens when it hits 0
// DONE  | ready high, waiting for Valid to drop before returning to IDLE
module mem_controller #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Valid,
  input  logic        RW,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              rw_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ram [0:(2**ADDR_W)-1];

  logic bad_req;
  logic complete;

  assign bad_req  = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
  assign complete = (state == ST_BUSY) && (cnt == 4'd0);
  // ready is decoded from state so an async reset raises it immediately
  assign ready    = (state != ST_BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      err     <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Valid) begin
            rw_q    <= RW;
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            err     <= bad_req;
            cnt     <= 4'(LATENCY - 1);
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (rw_q) rdata <= err ? 32'h0 : ram[idx_q];
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!Valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM is deliberately outside the reset domain; an aborted access never
  // reaches the completion edge, so its write is dropped.
  always_ff @(posedge clk) begin
    if (complete && !rw_q && !err) ram[idx_q] <= wdata_q;
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Memory-side responder for the processor's fetch/load/store traffic.
- The control unit raises Valid with RW, presents the address register and data bus contents, then waits for ready to fall and rise again.
- The block owns a word-addressed internal RAM and emulates a fixed multi-cycle access latency.
- On completion it returns read data or commits write data, and flags bad addresses.

Parameters:
- ADDR_W, 10, number of word-address bits; RAM holds 2**ADDR_W 32-bit words.
- LATENCY, 3, clock edges from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Valid  input  1  request strobe from control unit.
- RW  input  1  1 = read, 0 = write; sampled with Valid.
- addr  input  32  byte address from address register.
- wdata  input  32  store data from data bus.
- rdata  output  32  read data; holds the last completed read.
- ready  output  1  high = idle or done; low = access in progress.
- err  output  1  last accepted request was misaligned or out of range.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - ready=1, rdata=0, err=0.
  - State IDLE, latency counter 0, captured request registers 0.
  - RAM contents are not cleared.
- States:
  - IDLE: ready=1. At a clk edge with Valid=1, capture addr, RW and wdata, and set ready=0. Load counter=LATENCY-1. Go to BUSY.
  - BUSY: ready=0. If counter != 0, decrement it. If counter == 0, perform the access at this edge, set ready=1, and go to DONE.
  - DONE: ready=1. Stay while Valid=1. When Valid=0 at an edge, go to IDLE; no new request is accepted on that same edge.
- Latency and handshake:
  - Request accepted at edge N.
  - ready is low from after edge N through edge N+LATENCY-1.
  - ready rises after edge N+LATENCY.
  - rdata is valid at the same edge ready rises.
  - ready is always low for at least one full cycle, so the control unit's wait-low/wait-high sequence always completes.
- Holding Valid high after completion never retriggers an access. The requester must drop Valid for at least one edge between requests.
- addr, RW and wdata changes during BUSY or DONE are ignored; only the captured copies are used.
- Address decode:
  - Word index = captured addr[ADDR_W+1:2].
  - Misaligned when addr[1:0] != 0.
  - Out of range when addr[31:ADDR_W+2] != 0.
  - err is updated at acceptance: 1 if misaligned or out of range, else 0. It holds until the next acceptance.
- Read completion:
  - rdata <= RAM[index], or 32'h0 when err=1.
- Write completion:
  - RAM[index] <= wdata, committed only at the completion edge.
  - Suppressed when err=1.
  - rdata is unchanged.
- Reset mid-BUSY:
  - The access is aborted. A pending write is not committed. ready returns to 1 immediately.
- Valid=1 while in reset:
  - Ignored. After reset deasserts, a request still held on Valid is accepted at the first clk edge.
- LATENCY=1:
  - BUSY lasts one cycle; the access completes at edge N+1.

Test Plan:
1. Write then read, LATENCY=3:
   - Stimulus: Valid=1, RW=0, addr=0x10, wdata=0xDEADBEEF; hold until ready rises; drop Valid. Then Valid=1, RW=1, addr=0x10.
   - Required: ready low for exactly 3 cycles each time; rdata=0xDEADBEEF when ready rises; err=0.
2. Held Valid:
   - Stimulus: keep Valid=1 for 10 cycles after a read completes.
   - Required: ready stays 1, no second access, rdata unchanged. After Valid drops and re-asserts, a new access is accepted.
3. Misaligned and out-of-range:
   - Stimulus: read addr=0x12, then write addr=0x0000_1000 with ADDR_W=10 and wdata=0x5.
   - Required: err=1 for both requests; rdata=0 after the read. A subsequent read of word 0 (address 0x0) returns its prior value, proving the out-of-range write was suppressed.
4. Reset mid-write:
   - Stimulus: write 0x1234 to addr 0x20, whose prior value is 0xAAAA. Assert reset after the first BUSY cycle.
   - Required: ready=1 and err=0 immediately. A subsequent read of 0x20 returns 0xAAAA.
5. LATENCY=1 back-to-back:
   - Stimulus: fetch sequence at 0x0, 0x4, 0x8, with Valid dropped one cycle between requests.
   - Required: each access completes with ready low for exactly 1 cycle; rdata returns the three preloaded words in order.
6. Input changes during BUSY:
   - Stimulus: change addr and wdata mid-access.
   - Required: the access uses the values captured at acceptance.
